ram_phase_seq: RTL and testbench

RAM_PHASE_SEQ -- requirements
Module: ram_phase_seq

---
 rtl/ram_phase_seq.sv | 128 ++++++++++++
 tb/tb_ram_phase_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_phase_seq.sv
// RAM table loader and phase-accumulator playback sequencer (IDLE / LOAD / PLAY).
// Optional feature: define RAM_PHASE_SEQ_OFFSET_EN to add a phase_offset input applied to playback addressing.
module ram_phase_seq #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int FRAC_WIDTH    = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start_load,
    input  logic                                  load_valid,
    input  logic [DATA_WIDTH-1:0]                 load_data,
    output logic                                  load_ready,
    input  logic                                  play_en,
    input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0]   incr,
    output logic [ADDRESS_WIDTH-1:0]              ram_addr,
    output logic                                  ram_wr_en,
    output logic [DATA_WIDTH-1:0]                 ram_din,
    output logic                                  busy,
    output logic                                  wrap
`ifdef RAM_PHASE_SEQ_OFFSET_EN
    ,
    input  logic [ADDRESS_WIDTH-1:0]              phase_offset
`endif
);

    localparam int ACC_W = ADDRESS_WIDTH + FRAC_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE  = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] PTR_LAST = '1;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_e;

    state_e                   state_q, state_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    din_q, din_d;
    logic                     wr_q, wr_d;
    logic                     wrap_q, wrap_d;
    logic [ACC_W:0]           sum;
    logic [ADDRESS_WIDTH-1:0] offset;

`ifdef RAM_PHASE_SEQ_OFFSET_EN
    assign offset = phase_offset;
`else
    assign offset = '0;
`endif

    // The extra top bit of the sum is the accumulator carry-out that drives wrap.
    assign sum = {1'b0, acc_q} + {1'b0, incr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wr_q    <= wr_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_load)   state_d = LOAD;
                else if (play_en) state_d = PLAY;
            end
            LOAD: begin
                if (load_valid && ptr_q == PTR_LAST) state_d = IDLE;
            end
            PLAY: begin
                if (start_load)    state_d = LOAD;
                else if (!play_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outside LOAD the address follows the accumulator, so a pause simply holds it.
    always_comb begin
        acc_d  = acc_q;
        ptr_d  = ptr_q;
        addr_d = addr_q;
        din_d  = din_q;
        wr_d   = 1'b0;
        wrap_d = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (load_valid) begin
                    wr_d   = 1'b1;
                    addr_d = ptr_q;
                    din_d  = load_data;
                    ptr_d  = ptr_q + PTR_ONE;
                end
            end
            IDLE, PLAY: begin
                if (start_load) begin
                    acc_d = '0;
                    ptr_d = '0;
                end else if (state_q == PLAY && play_en) begin
                    acc_d  = sum[ACC_W-1:0];
                    wrap_d = sum[ACC_W];
                end
                addr_d = acc_d[ACC_W-1:FRAC_WIDTH] + offset;
            end
            default: ;
        endcase
    end

    assign load_ready = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign ram_addr   = addr_q;
    assign ram_wr_en  = wr_q;
    assign ram_din    = din_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_ram_phase_seq.sv
// Self-checking bench for ram_phase_seq: directed scenarios plus randomized traffic against a behavioural model.
// Define RAM_PHASE_SEQ_OFFSET_EN to also exercise the phase_offset input.
module tb_ram_phase_seq;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int FW  = 8;
    localparam int ACC_MOD  = 1 << (AW + FW);
    localparam int ADDR_MOD = 1 << AW;
    localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_load = 1'b0;
    logic            load_valid = 1'b0;
    logic [DW-1:0]   load_data = '0;
    logic            load_ready;
    logic            play_en = 1'b0;
    logic [AW+FW-1:0] incr = '0;
    logic [AW-1:0]   ram_addr;
    logic            ram_wr_en;
    logic [DW-1:0]   ram_din;
    logic            busy;
    logic            wrap;
    logic [AW-1:0]   phaseOffset = '0;

    int checks = 0;
    int errors = 0;
    int writeCount = 0;
    int wAddr [0:1023];
    int wData [0:1023];

    // Behavioural model state: mode, phase, load pointer and expected registered outputs.
    int    mMode = M_IDLE;
    longint mAcc = 0;
    int    mPtr = 0;
    int    mAddr = 0;
    int    mDin = 0;
    bit    mWr = 1'b0;
    bit    mWrap = 1'b0;

    ram_phase_seq #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FRAC_WIDTH(FW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_load (start_load),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .play_en    (play_en),
        .incr       (incr),
        .ram_addr   (ram_addr),
        .ram_wr_en  (ram_wr_en),
        .ram_din    (ram_din),
        .busy       (busy),
        .wrap       (wrap)
`ifdef RAM_PHASE_SEQ_OFFSET_EN
        ,
        .phase_offset (phaseOffset)
`endif
    );

    always #5 clk = ~clk;

    function automatic int offsetTerm();
`ifdef RAM_PHASE_SEQ_OFFSET_EN
        return int'(phaseOffset);
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: phase is plain modular arithmetic, address is its integer part.
    always @(posedge clk or negedge rst_n) begin
        longint sum;
        if (!rst_n) begin
            mMode = M_IDLE; mAcc = 0; mPtr = 0; mAddr = 0; mDin = 0; mWr = 0; mWrap = 0;
        end else begin
            mWr = 0;
            mWrap = 0;
            if (mMode == M_LOAD) begin
                if (load_valid) begin
                    mWr = 1; mAddr = mPtr; mDin = int'(load_data);
                    if (mPtr == ADDR_MOD - 1) mMode = M_IDLE;
                    mPtr = (mPtr + 1) % ADDR_MOD;
                end
            end else if (start_load) begin
                mMode = M_LOAD; mAcc = 0; mPtr = 0;
                mAddr = offsetTerm() % ADDR_MOD;
            end else begin
                if (play_en && mMode == M_PLAY) begin
                    sum = mAcc + longint'(incr);
                    mWrap = (sum >= ACC_MOD);
                    mAcc = sum % ACC_MOD;
                end
                mMode = play_en ? M_PLAY : M_IDLE;
                mAddr = int'((mAcc >> FW) + offsetTerm()) % ADDR_MOD;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("ram_addr",   32'(ram_addr),   32'(mAddr));
        checkOutput("ram_wr_en",  32'(ram_wr_en),  32'(mWr));
        checkOutput("ram_din",    32'(ram_din),    32'(mDin));
        checkOutput("wrap",       32'(wrap),       32'(mWrap));
        checkOutput("busy",       32'(busy),       32'(mMode != M_IDLE));
        checkOutput("load_ready", 32'(load_ready), 32'(mMode == M_LOAD));
        if (ram_wr_en && writeCount < 1024) begin
            wAddr[writeCount] = int'(ram_addr);
            wData[writeCount] = int'(ram_din);
            writeCount++;
        end
    end

    task automatic loadTable(input bit toggle);
        int idx = 0;
        int guard = 0;
        writeCount = 0;
        @(negedge clk) start_load = 1'b1;
        @(negedge clk) start_load = 1'b0;
        while (idx < ADDR_MOD && guard < 2000) begin
            if (!toggle || (guard % 2 == 0)) begin
                load_valid = 1'b1;
                load_data  = DW'(idx ^ 8'h5A);
                idx++;
            end else begin
                load_valid = 1'b0;
            end
            guard++;
            @(negedge clk);
        end
        load_valid = 1'b0;
        #1;
        checkOutput("load_bound", 32'(guard < 2000), 32'd1);
        checkOutput("load_ready_after_last", 32'(load_ready), 32'd0);
        checkOutput("busy_after_last", 32'(busy), 32'd0);
        checkOutput("write_count", 32'(writeCount), 32'd256);
        for (int i = 0; i < ADDR_MOD; i++) begin
            checkOutput("write_addr", 32'(wAddr[i]), 32'(i));
            checkOutput("write_data", 32'(wData[i]), 32'(i ^ 8'h5A));
        end
    endtask

    task automatic applyStimulus();
        start_load = ($urandom_range(0, 99) == 0);
        play_en    = ($urandom_range(0, 9) < 8);
        load_valid = $urandom_range(0, 1);
        load_data  = DW'($urandom);
        if ($urandom_range(0, 15) == 0) incr = (AW+FW)'($urandom);
        if ($urandom_range(0, 31) == 0) incr = '0;
        if ($urandom_range(0, 31) == 0) phaseOffset = AW'($urandom);
    endtask

    initial begin
        int wraps;
        int held;
        int lit [4] = '{1, 3, 4, 6};

        repeat (3) @(negedge clk);
        checkOutput("reset_addr", 32'(ram_addr), 32'd0);
        checkOutput("reset_wr", 32'(ram_wr_en), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ready", 32'(load_ready), 32'd0);
        checkOutput("reset_wrap", 32'(wrap), 32'd0);
        rst_n = 1'b1;

        loadTable(1'b0);
        loadTable(1'b1);

        // Playback from a cleared phase: fixed increment 0x0180.
        incr = 16'h0180;
        play_en = 1'b1;
        @(negedge clk);
        wraps = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (k <= 4) checkOutput("play_addr_seq", 32'(ram_addr), 32'(lit[k-1]));
            if (wrap) wraps++;
        end
        checkOutput("wrap_count", 32'(wraps), 32'd5);
        checkOutput("play_addr_1000", 32'(ram_addr), 32'd220);

        // Pause for five cycles, then resume from the held phase.
        held = int'(ram_addr);
        play_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("pause_hold", 32'(ram_addr), 32'(held));
        end
        checkOutput("pause_busy", 32'(busy), 32'd0);
        play_en = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("resume_addr", 32'(ram_addr), 32'd221);
        play_en = 1'b0;
        @(negedge clk);

        // Reset in the middle of a load at pointer 100.
        writeCount = 0;
        start_load = 1'b1;
        @(negedge clk) start_load = 1'b0;
        for (int i = 0; i < 100; i++) begin
            load_valid = 1'b1;
            load_data  = DW'(i);
            @(negedge clk);
        end
        #1;
        checkOutput("pre_reset_wr", 32'(ram_wr_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_wr", 32'(ram_wr_en), 32'd0);
        checkOutput("mid_reset_addr", 32'(ram_addr), 32'd0);
        checkOutput("mid_reset_din", 32'(ram_din), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        checkOutput("mid_reset_ready", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("mid_reset_writes", 32'(writeCount), 32'd100);
        rst_n = 1'b1;

`ifdef RAM_PHASE_SEQ_OFFSET_EN
        phaseOffset = 8'hF0;
        incr = 16'h2000;
        play_en = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("offset_addr", 32'(ram_addr), 32'h10);
        play_en = 1'b0;
        @(negedge clk);
        phaseOffset = '0;
`endif

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            applyStimulus();
        end
        @(negedge clk);
        start_load = 1'b0;
        play_en = 1'b0;
        load_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
